// File: rtl/mult_tdm_scheduler_pkg.sv
// Shared types for the TDM multiplier scheduler: FSM encoding, response tag
// layout and the requester-ID width helper.
package tdm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Widest ID needed for the supported NUM_REQ range (up to 8 requesters).
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_tdm_scheduler_if.sv
// Requester handshake, multiplier operand/product and response bundle
// between the requesters and the shared multiplier.
interface mult_tdm_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8,
    parameter int ID_W    = 1
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*WIDTH_A-1:0] req_a;
    logic [NUM_REQ*WIDTH_B-1:0] req_b;
    logic [WIDTH_A-1:0]         mult_a;
    logic [WIDTH_B-1:0]         mult_b;
    logic [WIDTH_A+WIDTH_B-1:0] mult_p;
    logic                       rsp_valid;
    logic [ID_W-1:0]            rsp_id;
    logic [WIDTH_A+WIDTH_B-1:0] rsp_data;

    modport master (
        output req_valid, req_a, req_b, mult_p,
        input  req_ready, mult_a, mult_b, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, mult_p,
        output req_ready, mult_a, mult_b, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mult_tdm_scheduler_rr_arbiter.sv
// Combinational round-robin grant: scans from ptr, wrapping, and grants the
// first valid requester; nothing is granted while en is low.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               hit
);
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j = (int'(ptr) + k) % NUM_REQ;
                if (!hit && req[j]) begin
                    hit      = 1'b1;
                    grant[j] = 1'b1;
                    idx      = ID_W'(j);
                end
            end
        end
    end
endmodule

// File: rtl/mult_tdm_scheduler.sv
// Time-shares one fixed-latency pipelined multiplier between NUM_REQ
// requesters; each product returns tagged with its requester ID.
module mult_tdm_scheduler
    import tdm_sched_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int WIDTH_A      = 8,
    parameter int WIDTH_B      = 8,
    parameter int MULT_LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    output logic                busy,
    mult_tdm_scheduler_if.slave bus
);
    localparam int ID_W   = id_width(NUM_REQ);
    localparam int CNT_W  = $clog2(MULT_LATENCY + 2);
    localparam int STAGES = MULT_LATENCY + 1;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DRAIN = DRAIN;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gidx;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   inflight_nxt;
    logic [WIDTH_A-1:0] opa_p0;
    logic [WIDTH_B-1:0] opb_p0;
    tag_t               tag_p [STAGES];
    tag_t               tag_out;
    logic [MAX_ID_W-1:0] tag_id_unused;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .en    (state == S_RUN),
        .grant (grant),
        .idx   (gidx),
        .hit   (accept)
    );

    assign bus.req_ready = grant;
    assign bus.mult_a    = opa_p0;
    assign bus.mult_b    = opb_p0;
    assign bus.rsp_data  = bus.mult_p;
    assign busy          = (state != S_IDLE);

    // ID bits above ID_W are always zero; only the low bits leave the block.
    assign tag_out       = tag_p[STAGES-1];
    assign tag_id_unused = tag_out.id;
    assign bus.rsp_valid = tag_out.valid;
    assign bus.rsp_id    = tag_out.id[ID_W-1:0];

    always_comb begin
        inflight_nxt = inflight;
        if (accept && !tag_out.valid)
            inflight_nxt = inflight + CNT_W'(1);
        else if (!accept && tag_out.valid)
            inflight_nxt = inflight - CNT_W'(1);
    end

    // Leaving RUN looks at the post-edge count so a same-edge accept is drained.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (enable) state_nxt = S_RUN;
            S_RUN:   if (!enable) state_nxt = (inflight_nxt != '0) ? S_DRAIN : S_IDLE;
            S_DRAIN: begin
                if (enable)                  state_nxt = S_RUN;
                else if (inflight_nxt == '0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p0: operand issue and tag entry; tag pipe tracks multiplier latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            inflight <= '0;
            opa_p0   <= '0;
            opb_p0   <= '0;
            for (int s = 0; s < STAGES; s++) tag_p[s] <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= inflight_nxt;
            if (accept) begin
                opa_p0 <= bus.req_a[int'(gidx)*WIDTH_A +: WIDTH_A];
                opb_p0 <= bus.req_b[int'(gidx)*WIDTH_B +: WIDTH_B];
                rr_ptr <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
            end
            tag_p[0] <= '{valid: accept, id: MAX_ID_W'(gidx)};
            for (int s = 1; s < STAGES; s++) tag_p[s] <= tag_p[s-1];
        end
    end
endmodule

// File: tb/tb_mult_tdm_scheduler.sv
// Directed bench for mult_tdm_scheduler: a 2-requester and a 3-requester
// instance, each driving a 4-stage multiplier stub.
module tb_mult_tdm_scheduler;

    typedef struct {
        int id;
        int data;
        int cyc;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en2 = 1'b0;
    logic en3 = 1'b0;
    logic busy2;
    logic busy3;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    rec_t rq2[$];
    rec_t gq2[$];
    rec_t rq3[$];
    rec_t gq3[$];

    logic [15:0] p2 [4];
    logic [15:0] p3 [4];

    always #5 clk = ~clk;

    mult_tdm_scheduler_if #(.NUM_REQ(2), .WIDTH_A(8), .WIDTH_B(8), .ID_W(1)) bus2();
    mult_tdm_scheduler_if #(.NUM_REQ(3), .WIDTH_A(8), .WIDTH_B(8), .ID_W(2)) bus3();

    mult_tdm_scheduler #(.NUM_REQ(2), .WIDTH_A(8), .WIDTH_B(8), .MULT_LATENCY(4)) dut2 (
        .clk(clk), .rst(rst), .enable(en2), .busy(busy2), .bus(bus2)
    );

    mult_tdm_scheduler #(.NUM_REQ(3), .WIDTH_A(8), .WIDTH_B(8), .MULT_LATENCY(4)) dut3 (
        .clk(clk), .rst(rst), .enable(en3), .busy(busy3), .bus(bus3)
    );

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        p2[0] <= 16'(bus2.mult_a) * 16'(bus2.mult_b);
        p3[0] <= 16'(bus3.mult_a) * 16'(bus3.mult_b);
        for (int k = 1; k < 4; k++) begin
            p2[k] <= p2[k-1];
            p3[k] <= p3[k-1];
        end
    end
    assign bus2.mult_p = p2[3];
    assign bus3.mult_p = p3[3];

    always @(negedge clk) begin
        if (bus2.rsp_valid === 1'b1)
            rq2.push_back('{int'(bus2.rsp_id), int'(bus2.rsp_data), cyc});
        if (bus3.rsp_valid === 1'b1)
            rq3.push_back('{int'(bus3.rsp_id), int'(bus3.rsp_data), cyc});
        for (int i = 0; i < 2; i++)
            if (bus2.req_ready[i] === 1'b1) gq2.push_back('{i, int'(bus2.req_a[i*8 +: 8]), cyc});
        for (int i = 0; i < 3; i++)
            if (bus3.req_ready[i] === 1'b1) gq3.push_back('{i, int'(bus3.req_a[i*8 +: 8]), cyc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rq2.delete(); gq2.delete(); rq3.delete(); gq3.delete();
    endtask

    task automatic test_reset();
        total++; if (bus2.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", bus2.rsp_valid); end
        total++; if (bus2.mult_a !== 8'h00) begin bad++; $display("FAIL reset_mult_a got=%h want=00", bus2.mult_a); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy2); end
        total++; if (bus2.req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", bus2.req_ready); end
        total++; if (bus2.rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id got=%h want=0", bus2.rsp_id); end
        rst = 1'b1;
        tick();
        en2 = 1'b1;
        bus2.req_valid = 2'b11;
        bus2.req_a = {8'd7, 8'd6};
        bus2.req_b = {8'd3, 8'd2};
        tick();
        repeat (3) tick();
        total++; if (bus2.mult_a !== 8'd6) begin bad++; $display("FAIL midrun_mult_a got=%h want=06", bus2.mult_a); end
        rst = 1'b0;
        #1;
        total++; if (bus2.mult_a !== 8'h00) begin bad++; $display("FAIL async_mult_a got=%h want=00", bus2.mult_a); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL async_busy got=%b want=0", busy2); end
        en2 = 1'b0;
        bus2.req_valid = 2'b00;
        tick();
        rst = 1'b1;
        clear_logs();
        repeat (10) tick();
        total++; if (rq2.size() != 0) begin bad++; $display("FAIL post_reset_rsp count got=%0d want=0", rq2.size()); end
        total++; if (bus2.mult_a !== 8'h00) begin bad++; $display("FAIL post_reset_mult_a got=%h want=00", bus2.mult_a); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy2); end
    endtask

    task automatic test_rotate();
        int want;
        clear_logs();
        en2 = 1'b1;
        bus2.req_valid = 2'b11;
        bus2.req_b = {8'd3, 8'd2};
        for (int t = 0; t < 12; t++) begin
            bus2.req_a = {8'(t + 10), 8'(t + 10)};
            tick();
        end
        bus2.req_valid = 2'b00;
        repeat (8) tick();
        en2 = 1'b0;
        repeat (2) tick();
        total++; if (gq2.size() != 11) begin bad++; $display("FAIL rotate_grants got=%0d want=11", gq2.size()); end
        total++; if (rq2.size() != 11) begin bad++; $display("FAIL rotate_rsps got=%0d want=11", rq2.size()); end
        for (int k = 0; k < 11 && k < gq2.size(); k++) begin
            total++; if (gq2[k].id != k % 2) begin bad++; $display("FAIL rotate_grant_id[%0d] got=%0d want=%0d", k, gq2[k].id, k % 2); end
        end
        for (int k = 0; k < 11 && k < rq2.size(); k++) begin
            want = (k + 11) * ((k % 2 == 1) ? 3 : 2);
            total++; if (rq2[k].id != k % 2) begin bad++; $display("FAIL rotate_rsp_id[%0d] got=%0d want=%0d", k, rq2[k].id, k % 2); end
            total++; if (rq2[k].data != want) begin bad++; $display("FAIL rotate_rsp_data[%0d] got=%0d want=%0d", k, rq2[k].data, want); end
            if (k < gq2.size()) begin
                total++; if (rq2[k].cyc != gq2[k].cyc + 5) begin bad++; $display("FAIL rotate_latency[%0d] got=%0d want=5", k, rq2[k].cyc - gq2[k].cyc); end
            end
        end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL rotate_end_busy got=%b want=0", busy2); end
    endtask

    task automatic test_single();
        clear_logs();
        en2 = 1'b1;
        bus2.req_valid = 2'b00;
        tick();
        bus2.req_valid = 2'b10;
        bus2.req_b = {8'd5, 8'd9};
        for (int t = 0; t < 6; t++) begin
            bus2.req_a = {8'(t + 1), 8'd9};
            tick();
        end
        bus2.req_valid = 2'b11;
        tick();
        bus2.req_valid = 2'b00;
        repeat (8) tick();
        en2 = 1'b0;
        repeat (2) tick();
        total++; if (gq2.size() != 7) begin bad++; $display("FAIL single_grants got=%0d want=7", gq2.size()); end
        for (int k = 0; k < 6 && k < gq2.size(); k++) begin
            total++; if (gq2[k].id != 1) begin bad++; $display("FAIL single_grant_id[%0d] got=%0d want=1", k, gq2[k].id); end
        end
        if (gq2.size() == 7) begin
            total++; if (gq2[6].id != 0) begin bad++; $display("FAIL single_wrap_id got=%0d want=0", gq2[6].id); end
            total++; if (gq2[6].cyc != gq2[5].cyc + 1) begin bad++; $display("FAIL single_wrap_delay got=%0d want=1", gq2[6].cyc - gq2[5].cyc); end
        end
        total++; if (rq2.size() != 7) begin bad++; $display("FAIL single_rsps got=%0d want=7", rq2.size()); end
        for (int k = 0; k < 6 && k < rq2.size(); k++) begin
            total++; if (rq2[k].data != (k + 1) * 5) begin bad++; $display("FAIL single_rsp_data[%0d] got=%0d want=%0d", k, rq2[k].data, (k + 1) * 5); end
        end
        if (rq2.size() == 7) begin
            total++; if (rq2[6].id != 0 || rq2[6].data != 81) begin bad++; $display("FAIL single_last_rsp got=%0d/%0d want=0/81", rq2[6].id, rq2[6].data); end
        end
    endtask

    task automatic test_drain();
        int n;
        int idle_cyc;
        int want_id[4];
        want_id = '{1, 0, 1, 0};
        clear_logs();
        en2 = 1'b1;
        bus2.req_valid = 2'b00;
        tick();
        bus2.req_valid = 2'b11;
        bus2.req_a = {8'd4, 8'd3};
        bus2.req_b = {8'd6, 8'd5};
        repeat (4) tick();
        bus2.req_valid = 2'b00;
        en2 = 1'b0;
        tick();
        bus2.req_valid = 2'b11;
        #1;
        total++; if (bus2.req_ready !== 2'b00) begin bad++; $display("FAIL drain_ready got=%b want=00", bus2.req_ready); end
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL drain_busy got=%b want=1", busy2); end
        n = 0;
        while (busy2 === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        idle_cyc = cyc;
        bus2.req_valid = 2'b00;
        total++; if (n >= 20) begin bad++; $display("FAIL drain_timeout got=%0d cycles want<20", n); end
        total++; if (gq2.size() != 4) begin bad++; $display("FAIL drain_grants got=%0d want=4", gq2.size()); end
        total++; if (rq2.size() != 4) begin bad++; $display("FAIL drain_rsps got=%0d want=4", rq2.size()); end
        for (int k = 0; k < 4 && k < rq2.size(); k++) begin
            total++; if (rq2[k].id != want_id[k] || rq2[k].data != (want_id[k] == 1 ? 24 : 15)) begin
                bad++; $display("FAIL drain_rsp[%0d] got=%0d/%0d want=%0d/%0d", k, rq2[k].id, rq2[k].data, want_id[k], want_id[k] == 1 ? 24 : 15);
            end
        end
        if (rq2.size() > 0) begin
            total++; if (idle_cyc != rq2[rq2.size()-1].cyc + 1) begin bad++; $display("FAIL drain_idle_cycle got=%0d want=%0d", idle_cyc, rq2[rq2.size()-1].cyc + 1); end
        end
    endtask

    task automatic test_reenable();
        int want_id[4];
        int want_d[4];
        want_id = '{1, 0, 1, 0};
        want_d  = '{30, 12, 90, 56};
        clear_logs();
        en2 = 1'b1;
        bus2.req_valid = 2'b00;
        tick();
        bus2.req_valid = 2'b11;
        bus2.req_a = {8'd5, 8'd3};
        bus2.req_b = {8'd6, 8'd4};
        repeat (2) tick();
        bus2.req_valid = 2'b00;
        en2 = 1'b0;
        tick();
        bus2.req_valid = 2'b11;
        bus2.req_a = {8'd9, 8'd7};
        bus2.req_b = {8'd10, 8'd8};
        en2 = 1'b1;
        #1;
        total++; if (bus2.req_ready !== 2'b00) begin bad++; $display("FAIL reen_drain_ready got=%b want=00", bus2.req_ready); end
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL reen_drain_busy got=%b want=1", busy2); end
        tick();
        total++; if (bus2.req_ready !== 2'b10) begin bad++; $display("FAIL reen_resume_ready got=%b want=10", bus2.req_ready); end
        repeat (2) tick();
        bus2.req_valid = 2'b00;
        repeat (8) tick();
        en2 = 1'b0;
        repeat (2) tick();
        total++; if (rq2.size() != 4) begin bad++; $display("FAIL reen_rsps got=%0d want=4", rq2.size()); end
        for (int k = 0; k < 4 && k < rq2.size(); k++) begin
            total++; if (rq2[k].id != want_id[k] || rq2[k].data != want_d[k]) begin
                bad++; $display("FAIL reen_rsp[%0d] got=%0d/%0d want=%0d/%0d", k, rq2[k].id, rq2[k].data, want_id[k], want_d[k]);
            end
        end
    endtask

    task automatic test_extremes();
        int want_d3[3];
        want_d3 = '{6, 0, 65025};
        clear_logs();
        en2 = 1'b1;
        tick();
        bus2.req_valid = 2'b01;
        bus2.req_a = {8'h00, 8'hFF};
        bus2.req_b = {8'hFF, 8'hFF};
        tick();
        bus2.req_valid = 2'b10;
        tick();
        bus2.req_valid = 2'b00;
        repeat (8) tick();
        en2 = 1'b0;
        total++; if (rq2.size() != 2) begin bad++; $display("FAIL ext_rsps got=%0d want=2", rq2.size()); end
        if (rq2.size() == 2) begin
            total++; if (rq2[0].id != 0 || rq2[0].data != 16'hFE01) begin bad++; $display("FAIL ext_ff_ff got=%0d/%h want=0/fe01", rq2[0].id, rq2[0].data); end
            total++; if (rq2[1].id != 1 || rq2[1].data != 0) begin bad++; $display("FAIL ext_zero got=%0d/%h want=1/0", rq2[1].id, rq2[1].data); end
        end
        en3 = 1'b1;
        tick();
        bus3.req_valid = 3'b111;
        bus3.req_a = {8'hFF, 8'h00, 8'h02};
        bus3.req_b = {8'hFF, 8'h07, 8'h03};
        repeat (7) tick();
        bus3.req_valid = 3'b000;
        repeat (8) tick();
        en3 = 1'b0;
        repeat (2) tick();
        total++; if (gq3.size() != 7) begin bad++; $display("FAIL wrap3_grants got=%0d want=7", gq3.size()); end
        for (int k = 0; k < 7 && k < gq3.size(); k++) begin
            total++; if (gq3[k].id != k % 3) begin bad++; $display("FAIL wrap3_grant_id[%0d] got=%0d want=%0d", k, gq3[k].id, k % 3); end
        end
        total++; if (rq3.size() != 7) begin bad++; $display("FAIL wrap3_rsps got=%0d want=7", rq3.size()); end
        for (int k = 0; k < 7 && k < rq3.size(); k++) begin
            total++; if (rq3[k].id != k % 3 || rq3[k].data != want_d3[k % 3]) begin
                bad++; $display("FAIL wrap3_rsp[%0d] got=%0d/%0d want=%0d/%0d", k, rq3[k].id, rq3[k].data, k % 3, want_d3[k % 3]);
            end
        end
        total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL wrap3_end_busy got=%b want=0", busy3); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus2.req_valid = 2'b11;
        bus2.req_a = '0;
        bus2.req_b = '0;
        bus3.req_valid = '0;
        bus3.req_a = '0;
        bus3.req_b = '0;
        repeat (3) tick();
        test_reset();
        test_rotate();
        test_single();
        test_drain();
        test_reenable();
        test_extremes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
